fifo_uart_tx: RTL and testbench

//   Downstream drain stage for the 8-bit fifo_k buffer.
//   - Pops one byte whenever the FIFO is non-empty and the block is idle.
//   - Serialises the byte as an async UART frame on tx: start, DATA_W bits LSB-first,

---
 rtl/fifo_uart_tx_pkg.sv | 19 +
 rtl/fifo_uart_tx_baud_cnt.sv | 26 ++
 rtl/fifo_uart_tx.sv | 96 +++++++++
 tb/tb_fifo_uart_tx.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter (and a future receiver).
// State encodings and the serial line levels for idle, start and stop.
package fifo_uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_POP    = 3'd1,
    ST_FETCH  = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
    ST_PARITY = 3'd5,
    ST_STOP   = 3'd6
  } state_t;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

endpackage

// File: rtl/fifo_uart_tx_baud_cnt.sv
// Bit-period counter: counts while enabled, wraps at CLKS_PER_BIT-1 and
// flags the last clock of each serial bit.
module baud_cnt #(
  parameter int CLKS_PER_BIT = 16,
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic bit_end
);

  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       cnt <= '0;
    else if (clr)     cnt <= '0;
    else if (en)      cnt <= bit_end ? '0 : cnt + 1'b1;
  end

  assign bit_end = en && (cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a byte FIFO one entry at a time and serialises each entry as an
// async UART frame: start, DATA_W bits LSB-first, optional even parity, stop.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8,
  parameter int PARITY_EN    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] data_in,
  output logic              pop,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);
  import fifo_uart_tx_pkg::*;

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic              par;
  logic [BW-1:0]     bitcnt;
  logic              bit_end;
  logic              in_frame;

  assign in_frame = (state == ST_START) || (state == ST_DATA) ||
                    (state == ST_PARITY) || (state == ST_STOP);

  // Counter is held at zero outside the frame so START always gets a full bit.
  baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk     (clk),
    .reset   (reset),
    .en      (in_frame),
    .clr     (!in_frame),
    .bit_end (bit_end)
  );

  assign pop        = (state == ST_POP);
  assign busy       = (state != ST_IDLE);
  assign frame_done = (state == ST_STOP) && bit_end;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      shreg  <= '0;
      par    <= 1'b0;
      bitcnt <= '0;
      tx     <= LINE_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (!fifo_empty) state <= ST_POP;
        ST_POP:   state <= ST_FETCH;
        ST_FETCH: begin
          // FIFO output is valid this cycle, one clock after the pop strobe.
          shreg  <= data_in;
          par    <= ^data_in;
          bitcnt <= '0;
          tx     <= LINE_START;
          state  <= ST_START;
        end
        ST_START: if (bit_end) begin
          tx    <= shreg[0];
          state <= ST_DATA;
        end
        ST_DATA: if (bit_end) begin
          shreg <= shreg >> 1;
          if (bitcnt == LAST_BIT) begin
            if (PARITY_EN != 0) begin
              tx    <= par;
              state <= ST_PARITY;
            end else begin
              tx    <= LINE_STOP;
              state <= ST_STOP;
            end
          end else begin
            bitcnt <= bitcnt + 1'b1;
            tx     <= shreg[1];
          end
        end
        ST_PARITY: if (bit_end) begin
          tx    <= LINE_STOP;
          state <= ST_STOP;
        end
        ST_STOP: if (bit_end) state <= ST_IDLE;
        default: begin
          tx    <= LINE_IDLE;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: channel 0 without parity, channel 1 with even parity,
// each fed by a queue-style FIFO model and checked by a frame-level line monitor.
module tb_fifo_uart_tx;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] fake = '0, hide = '0;
  logic [1:0] fifo_empty, pop, tx, busy, frame_done;
  logic [7:0] data_in [2] = '{default: 8'h00};

  logic [7:0] fmem [2][256];
  int wr[2] = '{0, 0}, rd[2] = '{0, 0}, exp_rd[2] = '{0, 0}, underflow[2] = '{0, 0};
  int k[2] = '{0, 0}, frames[2] = '{0, 0}, done_cnt[2] = '{0, 0}, pops[2] = '{0, 0};
  int start_cyc[2] = '{0, 0}, end_cyc[2] = '{0, 0};
  bit active[2] = '{0, 0};
  logic [7:0] cur[2] = '{8'h00, 8'h00};
  int gaps [2][256];
  logic par_hist [256];
  int cyc = 0;
  int n_tests = 0, n_fail = 0;

  always #10 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(8), .PARITY_EN(0)) u_dut (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty[0]), .data_in(data_in[0]),
    .pop(pop[0]), .tx(tx[0]), .busy(busy[0]), .frame_done(frame_done[0]));

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(8), .PARITY_EN(1)) u_par (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty[1]), .data_in(data_in[1]),
    .pop(pop[1]), .tx(tx[1]), .busy(busy[1]), .frame_done(frame_done[1]));

  assign fifo_empty[0] = ((rd[0] == wr[0]) | hide[0]) & ~fake[0];
  assign fifo_empty[1] = ((rd[1] == wr[1]) | hide[1]) & ~fake[1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Expected line level for bit slot idx of a frame carrying d.
  function automatic logic exp_bit(input logic [7:0] d, input int idx, input bit par_en);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (par_en && idx == 9) return ^d;
    return 1'b1;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: data appears on data_in the cycle after a pop.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (pop[g]) begin
        if (rd[g] == wr[g]) underflow[g] <= underflow[g] + 1;
        else begin
          data_in[g] <= fmem[g][rd[g]];
          rd[g]      <= rd[g] + 1;
        end
      end
    end
  end

  // Line monitor: each frame must carry the next pushed byte, bit-exact per cycle.
  always @(negedge clk) begin
    int len;
    for (int g = 0; g < 2; g++) begin
      len = (10 + g) * CPB;
      if (!reset) active[g] = 1'b0;
      else begin
        if (pop[g]) pops[g]++;
        if (frame_done[g]) done_cnt[g]++;
        if (!active[g]) begin
          if (tx[g] == 1'b0) begin
            chk("frame_expected", exp_rd[g] < wr[g], 1);
            cur[g] = fmem[g][exp_rd[g] & 255];
            exp_rd[g]++;
            active[g] = 1'b1;
            k[g] = 0;
            start_cyc[g] = cyc;
            gaps[g][frames[g] & 255] = cyc - end_cyc[g] - 1;
          end else chk("idle_no_done", frame_done[g], 0);
        end
        if (active[g]) begin
          chk("tx_bit", tx[g], exp_bit(cur[g], k[g] / CPB, g == 1));
          chk("frame_done", frame_done[g], k[g] == len - 1);
          chk("busy_in_frame", busy[g], 1);
          if (g == 1 && k[g] == 9 * CPB + 1) par_hist[frames[1] & 255] = tx[1];
          if (k[g] == len - 1) begin
            active[g] = 1'b0;
            frames[g]++;
            end_cyc[g] = cyc;
          end else k[g]++;
        end
      end
    end
  end

  task automatic push(input int g, input logic [7:0] b);
    fmem[g][wr[g]] = b;
    wr[g]++;
  endtask

  task automatic drain(input int g, input int budget, input string tag);
    int n = 0;
    while (!(exp_rd[g] == wr[g] && !active[g] && !busy[g] && rd[g] == wr[g]) && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    chk(tag, n < budget, 1);
  endtask

  task automatic wait_frame_at(input int g, input int kk, input int budget, input string tag);
    int n = 0;
    while (!(active[g] && k[g] == kk) && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    chk(tag, n < budget, 1);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, f0, d0, push_cyc, lost0;
    lost0 = 0;
    // 1. Reset and idle with an empty FIFO
    repeat (2) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("rst_tx", tx[g], 1);
      chk("rst_pop", pop[g], 0);
      chk("rst_busy", busy[g], 0);
      chk("rst_done", frame_done[g], 0);
    end
    @(negedge clk); reset = 1'b1;
    repeat (20) begin
      @(negedge clk); #1;
      chk("idle_tx", tx[0], 1);
      chk("idle_pop", pop[0], 0);
      chk("idle_busy", busy[0], 0);
    end

    // 2. Single byte: latency, length, one pop, one done
    push_cyc = cyc;
    push(0, 8'h05);
    drain(0, 200, "t2_drain");
    chk("t2_latency", start_cyc[0] - push_cyc, 3);
    chk("t2_len", end_cyc[0] - start_cyc[0] + 1, 40);
    chk("t2_pops", pops[0], 1);
    chk("t2_done", done_cnt[0], 1);

    // 3. Three queued bytes go back-to-back with 3-cycle mark gaps
    p0 = pops[0]; f0 = frames[0]; d0 = done_cnt[0];
    hide[0] = 1'b1;
    push(0, 8'h09); push(0, 8'h2D); push(0, 8'h64);
    hide[0] = 1'b0;
    drain(0, 400, "t3_drain");
    chk("t3_pops", pops[0] - p0, 3);
    chk("t3_frames", frames[0] - f0, 3);
    chk("t3_done", done_cnt[0] - d0, 3);
    chk("t3_gap1", gaps[0][f0 + 1], 3);
    chk("t3_gap2", gaps[0][f0 + 2], 3);

    // 4. Even parity channel
    f0 = frames[1];
    push(1, 8'h07); push(1, 8'h03);
    drain(1, 300, "t4_drain");
    chk("t4_par07", par_hist[f0], 1);
    chk("t4_par03", par_hist[f0 + 1], 0);
    chk("t4_len", end_cyc[1] - start_cyc[1] + 1, 44);

    // 5. Reset during data bit 3; the in-flight byte is lost, the next goes whole
    p0 = pops[0]; f0 = frames[0];
    push(0, 8'hA5); push(0, 8'h3C);
    wait_frame_at(0, 17, 200, "t5_reach_bit3");
    #2 reset = 1'b0;
    #1;
    chk("t5_tx_async", tx[0], 1);
    chk("t5_busy_async", busy[0], 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    lost0 = 1;
    drain(0, 300, "t5_drain");
    chk("t5_pops", pops[0] - p0, 2);
    chk("t5_frames", frames[0] - f0, 1);

    // 6. fifo_empty toggling mid-frame must not cause a pop
    push(0, 8'h5A);
    wait_frame_at(0, 2, 200, "t6_start");
    p0 = pops[0];
    for (int i = 0; i < 6; i++) begin
      fake[0] = ~fake[0];
      repeat (3) @(negedge clk);
      #1;
    end
    fake[0] = 1'b0;
    drain(0, 200, "t6_drain");
    chk("t6_no_pop", pops[0] - p0, 0);
    chk("t6_underflow", underflow[0], 0);
    push(0, 8'hC3);
    drain(0, 200, "t6_next");
    chk("t6_next_pop", pops[0] - p0, 1);

    // Random bursty traffic on both channels
    for (int n = 0; n < 30; n++) begin
      push(int'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      if ($urandom_range(0, 3) != 0) repeat ($urandom_range(0, 60)) @(negedge clk);
      #1;
    end
    drain(0, 5000, "rnd_drain0");
    drain(1, 5000, "rnd_drain1");
    for (int g = 0; g < 2; g++) begin
      chk("fin_pops", pops[g], wr[g]);
      chk("fin_frames", frames[g], wr[g] - (g == 0 ? lost0 : 0));
      chk("fin_done", done_cnt[g], frames[g]);
      chk("fin_underflow", underflow[g], 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
